hazard_ctrl_mc: RTL and testbench
=================================

# hazard_ctrl_mc

- Parametrised multi-cycle hazard controller for the in-order RISC-V pipeline.
- Generates PC/IF-ID write control, ID/EX bubble insertion and whole-pipeline freeze.
- Covers three cases:
  - load-use hazards with a configurable load-to-use latency;
  - taken-branch flushes with a configurable wrong-path depth;
  - stalls from a multi-cycle data memory.
- Sits between ID decode/branch compare and the pipeline registers, and keeps saturating performance counters for stalls and flushes.

## Interface
Parameters:
- REG_W, 5: register index width.
- LOAD_LAT, 1: load-use stall cycles per hazard. Legal range 1..4.
- BR_FLUSH, 1: IF/ID flush cycles per taken branch. Legal range 1..2.
- CNT_W, 16: performance counter width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous and active-low.
- memread_idex_i  in  1  instruction in ID/EX is a load.
- rd_idex_i  in  REG_W  destination of the ID/EX instruction.
- rs1_ifid_i  in  REG_W  source 1 of the IF/ID instruction.
- rs2_ifid_i  in  REG_W  source 2 of the IF/ID instruction.
- use_rs2_ifid_i  in  1  IF/ID instruction actually reads rs2.
- branch_id_i  in  1  ID instruction is a conditional branch.
- equal_id_i  in  1  branch condition true (taken).
- mem_busy_i  in  1  data memory not ready; the pipeline must freeze.
- clr_cnt_i  in  1  synchronous clear of both counters.
- pc_write_o  out  1  PC update enable.
- ifid_stall_o  out  1  hold the IF/ID register.
- ifid_flush_o  out  1  zero the IF/ID register.
- bubble_o  out  1  force zero controls into ID/EX.
- pipe_stall_o  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- load_stall_cnt_o  out  CNT_W  load-use stall cycles.
- flush_cnt_o  out  CNT_W  taken-branch events.

## Operation
States: RUN, LSTALL, FLUSH. A down-counter ld_cnt (3 bits) tracks remaining load-use stall cycles.

Hazard condition:
- hz = memread_idex_i & (rd_idex_i != 0) & (rd_idex_i == rs1_ifid_i | (use_rs2_ifid_i & rd_idex_i == rs2_ifid_i)).
- Register x0 never causes a hazard.

Idle outputs: pc_write_o = 1; all other control outputs 0.

Priority: mem_busy_i, then LSTALL/FLUSH state activity, then hz, then taken branch.

mem_busy_i = 1, any state:
- Outputs: pipe_stall_o = 1, pc_write_o = 0, ifid_stall_o = 1, bubble_o = 0, ifid_flush_o = 0.
- State, ld_cnt and both counters hold.

RUN with hz:
- Outputs: pc_write_o = 0, ifid_stall_o = 1, bubble_o = 1.
- load_stall_cnt increments.
- If LOAD_LAT > 1: ld_cnt = LOAD_LAT-1 and go to LSTALL.
- Any branch in ID is ignored this cycle and re-evaluated once the stall ends (stall beats flush).

RUN with !hz & branch_id_i & equal_id_i:
- Outputs: ifid_flush_o = 1, pc_write_o = 1.
- flush_cnt increments.
- If BR_FLUSH = 2: go to FLUSH.

LSTALL:
- Same outputs as a hz cycle; load_stall_cnt increments.
- ld_cnt decrements; return to RUN on the cycle ld_cnt == 1.
- hz, branch_id_i and equal_id_i are ignored.

FLUSH:
- One cycle with ifid_flush_o = 1 and pc_write_o = 1; hz and branch inputs ignored.
- flush_cnt does not increment; return to RUN.

Counters:
- Saturate at all-ones.
- clr_cnt_i forces 0 and wins over a same-cycle increment.
- clr_cnt_i is honoured even while mem_busy_i = 1.

## Timing
- Control outputs are combinational from state and inputs. The hz reaction is zero-latency, in the same cycle as detection.
- Stall length: exactly LOAD_LAT cycles per hazard, excluding frozen (mem_busy) cycles.
- Flush length: exactly BR_FLUSH consecutive cycles with ifid_flush_o = 1.

While rst_i = 0:
- State = RUN, ld_cnt = 0, counters = 0.
- pc_write_o = 0, ifid_flush_o = 1, bubble_o = 1, ifid_stall_o = 0, pipe_stall_o = 0.

Reset asserted mid-LSTALL or mid-FLUSH:
- Takes effect immediately; no residual stall or flush after release.
- First cycle after release with no inputs active shows idle outputs.

mem_busy_i asserted on the cycle hz first fires:
- No bubble and no count that cycle.
- hz is re-evaluated when mem_busy_i drops.

## Test plan
- Reset: hold rst_i = 0 for 3 cycles -> pc_write_o = 0, ifid_flush_o = 1, bubble_o = 1; release with quiet inputs -> pc_write_o = 1, others 0, both counters 0.
- LOAD_LAT = 2, load rd = 5, rs1 = 5 -> pc_write_o = 0 and bubble_o = 1 for exactly 2 cycles, load_stall_cnt_o = 2.
  - Same stimulus with rd = 0 -> no stall.
  - rs2 = 5 with use_rs2_ifid_i = 0 -> no stall.
- BR_FLUSH = 2, taken branch -> ifid_flush_o = 1 for 2 cycles, pc_write_o = 1 throughout, flush_cnt_o = 1.
  - Taken branch with hz in the same cycle -> stall first, then one flush event; flush_cnt_o = 1.
- LOAD_LAT = 3, mem_busy_i high for 3 cycles starting in the 2nd stall cycle -> pipe_stall_o = 1 for those 3 cycles, then 2 more stall cycles; load_stall_cnt_o = 3.
- CNT_W = 4, 20 stall cycles -> load_stall_cnt_o = 15.
  - clr_cnt_i during a stall cycle -> counter reads 0 next cycle.
- Reset pulse during FLUSH (BR_FLUSH = 2) -> ifid_flush_o is driven by the reset value only; after release, state is RUN with idle outputs.

Source files
------------

// File: rtl/hazard_ctrl_mc_if.sv
// Control bundle between ID decode/branch compare and the hazard controller:
// hazard/branch/memory inputs in, pipeline-register controls and event counts out.
interface hazard_ctrl_mc_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             memread_idex_i;
  logic [REG_W-1:0] rd_idex_i;
  logic [REG_W-1:0] rs1_ifid_i;
  logic [REG_W-1:0] rs2_ifid_i;
  logic             use_rs2_ifid_i;
  logic             branch_id_i;
  logic             equal_id_i;
  logic             mem_busy_i;
  logic             clr_cnt_i;
  logic             pc_write_o;
  logic             ifid_stall_o;
  logic             ifid_flush_o;
  logic             bubble_o;
  logic             pipe_stall_o;
  logic [CNT_W-1:0] load_stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output memread_idex_i, rd_idex_i, rs1_ifid_i, rs2_ifid_i, use_rs2_ifid_i,
    output branch_id_i, equal_id_i, mem_busy_i, clr_cnt_i,
    input  pc_write_o, ifid_stall_o, ifid_flush_o, bubble_o, pipe_stall_o,
    input  load_stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  memread_idex_i, rd_idex_i, rs1_ifid_i, rs2_ifid_i, use_rs2_ifid_i,
    input  branch_id_i, equal_id_i, mem_busy_i, clr_cnt_i,
    output pc_write_o, ifid_stall_o, ifid_flush_o, bubble_o, pipe_stall_o,
    output load_stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl_mc.sv
// Multi-cycle hazard controller: load-use stalls, taken-branch flushes and
// data-memory freezes for the in-order pipeline, plus saturating event counters.
module hazard_ctrl_mc #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1,
  parameter int CNT_W    = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  hazard_ctrl_mc_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [2:0]       LD_INIT  = 3'(LOAD_LAT - 1);
  localparam bit               LD_MULTI = (LOAD_LAT > 1);
  localparam bit               FL_MULTI = (BR_FLUSH == 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  // Clear dominates; otherwise count up and stick at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc,
                                               input logic clr);
    logic [CNT_W-1:0] r;
    if (clr) begin
      r = {CNT_W{1'b0}};
    end else if (inc && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       ld_cnt_q, ld_cnt_d;
  logic [CNT_W-1:0] lcnt_q, fcnt_q;

  logic hz_s, taken_s, rd_nz_s;
  logic ld_inc_s, fl_inc_s;
  logic pc_write_s, ifid_stall_s, ifid_flush_s, bubble_s, pipe_stall_s;

  assign rd_nz_s = (bus.rd_idex_i != {REG_W{1'b0}});
  assign hz_s    = bus.memread_idex_i & rd_nz_s &
                   ((bus.rd_idex_i == bus.rs1_ifid_i) |
                    (bus.use_rs2_ifid_i & (bus.rd_idex_i == bus.rs2_ifid_i)));
  assign taken_s = bus.branch_id_i & bus.equal_id_i;

  // Next-state and control outputs; a memory freeze overrides every state.
  always_comb begin
    state_d      = state_q;
    ld_cnt_d     = ld_cnt_q;
    ld_inc_s     = 1'b0;
    fl_inc_s     = 1'b0;
    pc_write_s   = 1'b1;
    ifid_stall_s = 1'b0;
    ifid_flush_s = 1'b0;
    bubble_s     = 1'b0;
    pipe_stall_s = 1'b0;
    if (!rst_i) begin
      pc_write_s   = 1'b0;
      ifid_flush_s = 1'b1;
      bubble_s     = 1'b1;
    end else if (bus.mem_busy_i) begin
      pipe_stall_s = 1'b1;
      pc_write_s   = 1'b0;
      ifid_stall_s = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (hz_s) begin
            pc_write_s   = 1'b0;
            ifid_stall_s = 1'b1;
            bubble_s     = 1'b1;
            ld_inc_s     = 1'b1;
            if (LD_MULTI) begin
              state_d  = LSTALL;
              ld_cnt_d = LD_INIT;
            end else begin
              state_d  = RUN;
            end
          end else if (taken_s) begin
            ifid_flush_s = 1'b1;
            fl_inc_s     = 1'b1;
            if (FL_MULTI) begin
              state_d = FLUSH;
            end else begin
              state_d = RUN;
            end
          end else begin
            state_d = RUN;
          end
        end
        LSTALL: begin
          pc_write_s   = 1'b0;
          ifid_stall_s = 1'b1;
          bubble_s     = 1'b1;
          ld_inc_s     = 1'b1;
          ld_cnt_d     = ld_cnt_q - 3'd1;
          if (ld_cnt_q == 3'd1) begin
            state_d = RUN;
          end else begin
            state_d = LSTALL;
          end
        end
        FLUSH: begin
          ifid_flush_s = 1'b1;
          state_d      = RUN;
        end
        default: begin
          state_d  = RUN;
          ld_cnt_d = 3'd0;
        end
      endcase
    end
  end

  // FSM state and remaining load-use stall cycles.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= RUN;
      ld_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  // Performance counters; clear is honoured even while frozen.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lcnt_q <= {CNT_W{1'b0}};
      fcnt_q <= {CNT_W{1'b0}};
    end else begin
      lcnt_q <= sat_inc(lcnt_q, ld_inc_s, bus.clr_cnt_i);
      fcnt_q <= sat_inc(fcnt_q, fl_inc_s, bus.clr_cnt_i);
    end
  end

  assign bus.pc_write_o       = pc_write_s;
  assign bus.ifid_stall_o     = ifid_stall_s;
  assign bus.ifid_flush_o     = ifid_flush_s;
  assign bus.bubble_o         = bubble_s;
  assign bus.pipe_stall_o     = pipe_stall_s;
  assign bus.load_stall_cnt_o = lcnt_q;
  assign bus.flush_cnt_o      = fcnt_q;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench: table of vectors against a LOAD_LAT=2/BR_FLUSH=2 instance, and
// hand sequences against a LOAD_LAT=3/BR_FLUSH=1/CNT_W=4 instance.
module tb_hazard_ctrl_mc;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;
  // {pc_write, ifid_stall, ifid_flush, bubble, pipe_stall}
  localparam logic [4:0] C_IDLE = 5'b10000;
  localparam logic [4:0] C_STL  = 5'b01010;
  localparam logic [4:0] C_FL   = 5'b10100;
  localparam logic [4:0] C_BSY  = 5'b01001;
  localparam logic [4:0] C_RST  = 5'b00110;

  typedef struct packed {
    logic        rst;
    logic        mr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u2;
    logic        br;
    logic        eq;
    logic        busy;
    logic        clr;
    logic [4:0]  ctl;
    logic [15:0] lc;
    logic [15:0] fc;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t tbl[$];

  always #5 clk_i = ~clk_i;

  hazard_ctrl_mc_if #(.REG_W(5), .CNT_W(16)) ifa ();
  hazard_ctrl_mc_if #(.REG_W(5), .CNT_W(4))  ifb ();

  hazard_ctrl_mc #(.REG_W(5), .LOAD_LAT(2), .BR_FLUSH(2), .CNT_W(16)) dut_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifa.slave)
  );

  hazard_ctrl_mc #(.REG_W(5), .LOAD_LAT(3), .BR_FLUSH(1), .CNT_W(4)) dut_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (ifb.slave)
  );

  logic [4:0] ctl_a, ctl_b;
  assign ctl_a = {ifa.pc_write_o, ifa.ifid_stall_o, ifa.ifid_flush_o, ifa.bubble_o, ifa.pipe_stall_o};
  assign ctl_b = {ifb.pc_write_o, ifb.ifid_stall_o, ifb.ifid_flush_o, ifb.bubble_o, ifb.pipe_stall_o};

  function automatic vec_t mk(input logic rst, mr, input logic [4:0] rd, rs1, rs2,
                              input logic u2, br, eq, busy, clr,
                              input logic [4:0] ctl, input logic [15:0] lc, fc);
    vec_t v;
    v.rst = rst; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.u2 = u2; v.br = br; v.eq = eq; v.busy = busy; v.clr = clr;
    v.ctl = ctl; v.lc = lc; v.fc = fc;
    return v;
  endfunction

  function automatic vec_t q();
    return mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd0, 16'd0);
  endfunction

  task automatic set_in(input vec_t v);
    rst_i = v.rst;
    ifa.memread_idex_i = v.mr;  ifb.memread_idex_i = v.mr;
    ifa.rd_idex_i      = v.rd;  ifb.rd_idex_i      = v.rd;
    ifa.rs1_ifid_i     = v.rs1; ifb.rs1_ifid_i     = v.rs1;
    ifa.rs2_ifid_i     = v.rs2; ifb.rs2_ifid_i     = v.rs2;
    ifa.use_rs2_ifid_i = v.u2;  ifb.use_rs2_ifid_i = v.u2;
    ifa.branch_id_i    = v.br;  ifb.branch_id_i    = v.br;
    ifa.equal_id_i     = v.eq;  ifb.equal_id_i     = v.eq;
    ifa.mem_busy_i     = v.busy; ifb.mem_busy_i    = v.busy;
    ifa.clr_cnt_i      = v.clr; ifb.clr_cnt_i      = v.clr;
  endtask

  task automatic apply(input vec_t v);
    set_in(v);
    @(negedge clk_i);
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    int   nb;
    // rst mr rd rs1 rs2 u2 br eq busy clr | ctl lc fc  (LOAD_LAT=2, BR_FLUSH=2)
    tbl.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_RST,  16'd0, 16'd0));
    tbl.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_RST,  16'd0, 16'd0));
    tbl.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_RST,  16'd0, 16'd0));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd0, 16'd0));
    tbl.push_back(mk(H, H, 5'd5, 5'd5, 5'd0, L, L, L, L, L, C_STL,  16'd0, 16'd0));
    tbl.push_back(mk(H, H, 5'd5, 5'd5, 5'd0, L, L, L, L, L, C_STL,  16'd1, 16'd0));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd2, 16'd0));
    tbl.push_back(mk(H, H, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd2, 16'd0));
    tbl.push_back(mk(H, H, 5'd5, 5'd3, 5'd5, L, L, L, L, L, C_IDLE, 16'd2, 16'd0));
    tbl.push_back(mk(H, H, 5'd5, 5'd3, 5'd5, H, L, L, L, L, C_STL,  16'd2, 16'd0));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_STL,  16'd3, 16'd0));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, H, H, L, L, C_FL,   16'd4, 16'd0));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, H, H, L, L, C_FL,   16'd4, 16'd1));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd4, 16'd1));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, H, L, L, L, C_IDLE, 16'd4, 16'd1));
    tbl.push_back(mk(H, H, 5'd7, 5'd7, 5'd0, L, H, H, L, L, C_STL,  16'd4, 16'd1));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, H, H, L, L, C_STL,  16'd5, 16'd1));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, H, H, L, L, C_FL,   16'd6, 16'd1));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_FL,   16'd6, 16'd2));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd6, 16'd2));
    tbl.push_back(mk(H, H, 5'd4, 5'd4, 5'd0, L, L, L, H, L, C_BSY,  16'd6, 16'd2));
    tbl.push_back(mk(H, H, 5'd4, 5'd4, 5'd0, L, L, L, L, L, C_STL,  16'd6, 16'd2));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, H, L, C_BSY,  16'd7, 16'd2));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_STL,  16'd7, 16'd2));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd8, 16'd2));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, H, H, C_BSY,  16'd8, 16'd2));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd0, 16'd0));
    tbl.push_back(mk(H, H, 5'd9, 5'd9, 5'd0, L, L, L, L, H, C_STL,  16'd0, 16'd0));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_STL,  16'd0, 16'd0));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd1, 16'd0));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, H, H, L, L, C_FL,   16'd1, 16'd0));
    tbl.push_back(mk(L, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_RST,  16'd0, 16'd0));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd0, 16'd0));
    tbl.push_back(mk(H, L, 5'd0, 5'd0, 5'd0, L, L, L, L, L, C_IDLE, 16'd0, 16'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      chk($sformatf("a_row%0d_ctl", i), {27'd0, ctl_a}, {27'd0, tbl[i].ctl});
      chk($sformatf("a_row%0d_lcnt", i), {16'd0, ifa.load_stall_cnt_o}, {16'd0, tbl[i].lc});
      chk($sformatf("a_row%0d_fcnt", i), {16'd0, ifa.flush_cnt_o}, {16'd0, tbl[i].fc});
      adv();
    end

    // Instance B: LOAD_LAT=3 stall interrupted by a 3-cycle memory freeze.
    v = q(); v.rst = L; apply(v); adv();
    v = q(); apply(v);
    chk("b_release_ctl", {27'd0, ctl_b}, {27'd0, C_IDLE});
    chk("b_release_lcnt", {28'd0, ifb.load_stall_cnt_o}, 32'd0);
    adv();
    v = q(); v.mr = H; v.rd = 5'd5; v.rs1 = 5'd5; apply(v);
    chk("b_hz_ctl", {27'd0, ctl_b}, {27'd0, C_STL}); adv();
    v = q(); v.busy = H;
    for (int k = 0; k < 3; k++) begin
      apply(v); chk($sformatf("b_busy%0d_ctl", k), {27'd0, ctl_b}, {27'd0, C_BSY}); adv();
    end
    v = q();
    for (int k = 0; k < 2; k++) begin
      apply(v); chk($sformatf("b_lstall%0d_ctl", k), {27'd0, ctl_b}, {27'd0, C_STL}); adv();
    end
    apply(v);
    chk("b_after_stall_ctl", {27'd0, ctl_b}, {27'd0, C_IDLE});
    chk("b_after_stall_lcnt", {28'd0, ifb.load_stall_cnt_o}, 32'd3);
    adv();

    // Instance B: single-cycle flush.
    v = q(); v.br = H; v.eq = H; apply(v);
    chk("b_flush_ctl", {27'd0, ctl_b}, {27'd0, C_FL}); adv();
    v = q(); apply(v);
    chk("b_flush_end_ctl", {27'd0, ctl_b}, {27'd0, C_IDLE});
    chk("b_flush_fcnt", {28'd0, ifb.flush_cnt_o}, 32'd1);
    adv();

    // Instance B: 20 stall cycles saturate the 4-bit counter, then clear.
    v = q(); v.rst = L; apply(v); adv();
    nb = 0;
    v = q(); v.mr = H; v.rd = 5'd6; v.rs2 = 5'd6; v.u2 = H;
    for (int k = 0; k < 20; k++) begin
      apply(v);
      if (ifb.bubble_o === 1'b1 && ifb.pc_write_o === 1'b0) nb++;
      adv();
    end
    chk("b_sat_bubbles", nb, 32'd20);
    v.clr = H; apply(v);
    chk("b_sat_lcnt", {28'd0, ifb.load_stall_cnt_o}, 32'd15);
    chk("b_clr_cycle_ctl", {27'd0, ctl_b}, {27'd0, C_STL});
    adv();
    v.clr = L; apply(v);
    chk("b_clr_lcnt", {28'd0, ifb.load_stall_cnt_o}, 32'd0);
    adv();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
